// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, read-valid strobe and sticky error flags.
module sync_fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr,
    input  logic                     rd,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     dout_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int AW  = $clog2(DEPTH);
    localparam int AW1 = AW + 1;
    localparam logic [AW:0] FULL_C = AW1'(DEPTH);
    localparam logic [AW:0] AF_C   = AW1'(AF_LEVEL);
    localparam logic [AW:0] AE_C   = AW1'(AE_LEVEL);

    if ((WIDTH < 1) || (DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) ||
        (AF_LEVEL < 1) || (AF_LEVEL > DEPTH) ||
        (AE_LEVEL < 0) || (AE_LEVEL > DEPTH - 1)) begin : g_bad_param
        $fatal(1, "sync_fifo_param: illegal WIDTH/DEPTH/AF_LEVEL/AE_LEVEL");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dv_q, dv_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             full_s, empty_s, wr_acc_s, rd_acc_s;

    // Flags decode the registered count, so acceptance sees pre-edge state.
    assign full_s   = (count_q == FULL_C);
    assign empty_s  = (count_q == {AW1{1'b0}});
    assign wr_acc_s = wr & ~full_s;
    assign rd_acc_s = rd & ~empty_s;

    // Next-state computation for pointers, count, read data and error flags.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        dout_d  = dout_q;
        dv_d    = 1'b0;
        ovf_d   = ovf_q | (wr & full_s);
        unf_d   = unf_q | (rd & empty_s);
        if (wr_acc_s) begin
            wptr_d = wptr_q + AW'(1);
        end else begin
            wptr_d = wptr_q;
        end
        if (rd_acc_s) begin
            rptr_d = rptr_q + AW'(1);
            dout_d = mem_q[rptr_q];
            dv_d   = 1'b1;
        end else begin
            rptr_d = rptr_q;
            dout_d = dout_q;
            dv_d   = 1'b0;
        end
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_d = count_q + AW1'(1);
            2'b01:   count_d = count_q - AW1'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= {AW{1'b0}};
            rptr_q  <= {AW{1'b0}};
            count_q <= {AW1{1'b0}};
            dout_q  <= {WIDTH{1'b0}};
            dv_q    <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage array; contents survive reset and are only reachable via pointers.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc_s) begin
            mem_q[wptr_q] <= din;
        end
    end

    assign dout         = dout_q;
    assign dout_valid   = dv_q;
    assign full         = full_s;
    assign empty        = empty_s;
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, randomized traffic, and a 32x4 instance.
module tb_sync_fifo_param;
    logic        clk = 1'b0;
    logic        rst, wr, rd;
    logic [7:0]  din, dout;
    logic        dout_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0]  count;

    logic        b_rst, b_wr, b_rd;
    logic [31:0] b_din, b_dout;
    logic        b_dv, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
    logic [2:0]  b_count;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    logic [7:0] mq[$];
    logic [7:0] m_dout;
    logic       m_dv, m_ovf, m_unf;

    always #5 clk = ~clk;

    sync_fifo_param u_a (
        .clk(clk), .rst(rst), .wr(wr), .rd(rd), .din(din), .dout(dout),
        .dout_valid(dout_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    sync_fifo_param #(.WIDTH(32), .DEPTH(4), .AF_LEVEL(4), .AE_LEVEL(0)) u_b (
        .clk(clk), .rst(b_rst), .wr(b_wr), .rd(b_rd), .din(b_din), .dout(b_dout),
        .dout_valid(b_dv), .full(b_full), .empty(b_empty),
        .almost_full(b_af), .almost_empty(b_ae), .count(b_count),
        .overflow(b_ovf), .underflow(b_unf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of words, updated from the inputs seen at each edge.
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_dout = 8'h00;
            m_dv   = 1'b0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
        end else begin
            automatic bit was_full  = (mq.size() == 16);
            automatic bit was_empty = (mq.size() == 0);
            if (wr && was_full)  m_ovf = 1'b1;
            if (rd && was_empty) m_unf = 1'b1;
            m_dv = 1'b0;
            if (rd && !was_empty) begin
                m_dout = mq.pop_front();
                m_dv   = 1'b1;
            end
            if (wr && !was_full) mq.push_back(din);
        end
    end

    // Every-cycle comparison of all outputs of the default instance.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("count",        32'(count),        32'(mq.size()));
            chk("full",         32'(full),         32'(mq.size() == 16));
            chk("empty",        32'(empty),        32'(mq.size() == 0));
            chk("almost_full",  32'(almost_full),  32'(mq.size() >= 14));
            chk("almost_empty", 32'(almost_empty), 32'(mq.size() <= 2));
            chk("dout",         32'(dout),         32'(m_dout));
            chk("dout_valid",   32'(dout_valid),   32'(m_dv));
            chk("overflow",     32'(overflow),     32'(m_ovf));
            chk("underflow",    32'(underflow),    32'(m_unf));
        end
    end

    task automatic cyc(input logic w, input logic r, input logic [7:0] d, input logic rs);
        wr = w; rd = r; din = d; rst = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic cycb(input logic w, input logic r, input logic [31:0] d);
        b_wr = w; b_rd = r; b_din = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        wr = 1'b0; rd = 1'b0; din = 8'h00; rst = 1'b1;
        b_wr = 1'b0; b_rd = 1'b0; b_din = 32'h0; b_rst = 1'b1;
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk_en = 1'b1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_ae",    32'(almost_empty), 32'd1);
        chk("rst_af",    32'(almost_full), 32'd0);
        chk("rst_dout",  32'(dout), 32'd0);

        // Fill with 0x01..0x10.
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1, 1'b0, 8'(i), 1'b0);
            chk("t1_count", 32'(count), 32'(i));
            chk("t1_ae",    32'(almost_empty), 32'(i <= 2));
            chk("t1_af",    32'(almost_full), 32'(i >= 14));
            chk("t1_full",  32'(full), 32'(i == 16));
        end
        chk("t1_ovf", 32'(overflow), 32'd0);

        // Overflow attempt, then drain in order.
        cyc(1'b1, 1'b0, 8'hAA, 1'b0);
        chk("t2_ovf",   32'(overflow), 32'd1);
        chk("t2_count", 32'(count), 32'd16);
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b0, 1'b1, 8'h00, 1'b0);
            chk("t2_dout", 32'(dout), 32'(i));
            chk("t2_dv",   32'(dout_valid), 32'd1);
        end
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        chk("t2_dv_end", 32'(dout_valid), 32'd0);
        chk("t2_empty",  32'(empty), 32'd1);
        chk("t2_hold",   32'(dout), 32'h10);
        chk("t2_ovf_sticky", 32'(overflow), 32'd1);

        // Simultaneous write/read on empty.
        cyc(1'b1, 1'b1, 8'h5A, 1'b0);
        chk("t3_unf",   32'(underflow), 32'd1);
        chk("t3_count", 32'(count), 32'd1);
        chk("t3_dv",    32'(dout_valid), 32'd0);
        cyc(1'b0, 1'b1, 8'h00, 1'b0);
        chk("t3_dout", 32'(dout), 32'h5A);
        chk("t3_dv2",  32'(dout_valid), 32'd1);

        // Steady state at count 8 with concurrent traffic across wraps.
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk("t4_ovf_clr", 32'(overflow), 32'd0);
        chk("t4_unf_clr", 32'(underflow), 32'd0);
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 8'(i), 1'b0);
        for (int j = 0; j < 40; j++) begin
            cyc(1'b1, 1'b1, 8'(8 + j), 1'b0);
            chk("t4_count", 32'(count), 32'd8);
            chk("t4_dout",  32'(dout), 32'(j));
        end
        chk("t4_ovf", 32'(overflow), 32'd0);
        chk("t4_unf", 32'(underflow), 32'd0);

        // Reset mid-traffic at count 10.
        cyc(1'b1, 1'b0, 8'd48, 1'b0);
        cyc(1'b1, 1'b0, 8'd49, 1'b0);
        chk("t5_count10", 32'(count), 32'd10);
        cyc(1'b1, 1'b1, 8'h33, 1'b1);
        chk("t5_count", 32'(count), 32'd0);
        chk("t5_empty", 32'(empty), 32'd1);
        chk("t5_dout",  32'(dout), 32'd0);
        chk("t5_dv",    32'(dout_valid), 32'd0);
        cyc(1'b1, 1'b0, 8'h77, 1'b0);
        cyc(1'b0, 1'b1, 8'h00, 1'b0);
        chk("t5_new", 32'(dout), 32'h77);
        chk("t5_dv2", 32'(dout_valid), 32'd1);

        // Randomized traffic in write-heavy, read-heavy and balanced phases.
        for (int k = 0; k < 3000; k++) begin
            automatic int ph = (k / 300) % 3;
            automatic int pw = (ph == 0) ? 70 : ((ph == 1) ? 30 : 50);
            automatic logic w  = ($urandom_range(0, 99) < pw);
            automatic logic r  = ($urandom_range(0, 99) < (100 - pw));
            automatic logic rs = ($urandom_range(0, 299) == 0);
            cyc(w, r, 8'($urandom), rs);
        end
        cyc(1'b0, 1'b0, 8'h00, 1'b0);

        // Second configuration: 32-bit x 4, thresholds at the extremes.
        b_rst = 1'b0;
        cycb(1'b0, 1'b0, 32'h0);
        chk("b_rst_ae", 32'(b_ae), 32'd1);
        chk("b_rst_af", 32'(b_af), 32'd0);
        cycb(1'b1, 1'b0, 32'hDEADBEEF);
        chk("b_count1", 32'(b_count), 32'd1);
        chk("b_ae1",    32'(b_ae), 32'd0);
        chk("b_af1",    32'(b_af), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cycb(1'b1, 1'b0, 32'(i + 100));
            chk("b_af_eq_full", 32'(b_af), 32'(b_full));
        end
        chk("b_full", 32'(b_full), 32'd1);
        chk("b_af4",  32'(b_af), 32'd1);
        cycb(1'b0, 1'b1, 32'h0);
        chk("b_dout", b_dout, 32'hDEADBEEF);
        chk("b_dv",   32'(b_dv), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cycb(1'b0, 1'b1, 32'h0);
            chk("b_dout_n", b_dout, 32'(i + 100));
            chk("b_ae_eq_empty", 32'(b_ae), 32'(b_empty));
        end
        chk("b_empty", 32'(b_empty), 32'd1);
        chk("b_ae0",   32'(b_ae), 32'd1);
        chk("b_unf",   32'(b_unf), 32'd0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised single-clock synchronous FIFO, the next generation of the team's 8-bit × 16 FIFO. It generalises data width and depth and supports simultaneous read and write in one cycle. It adds an occupancy count, programmable almost-full/almost-empty flags, a read-data valid strobe and sticky overflow/underflow error flags. It sits between producer and consumer blocks in the datapath and serves as the standard buffering primitive for the verification environment.

Parameters:
WIDTH, 8, data word width in bits (≥1)
DEPTH, 16, number of entries; power of two, ≥2; AW = log2(DEPTH)
AF_LEVEL, DEPTH-2, almost_full asserts when count ≥ AF_LEVEL; legal range 1..DEPTH
AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL; legal range 0..DEPTH-1

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset; synchronous, active-high
wr  in  1  write request
rd  in  1  read request
din  in  WIDTH  write data
dout  out  WIDTH  read data, registered
dout_valid  out  1  high for exactly one cycle after an accepted read
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count ≥ AF_LEVEL
almost_empty  out  1  count ≤ AE_LEVEL
count  out  AW+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: a write was attempted while full
underflow  out  1  sticky: a read was attempted while empty

Behaviour:
- Reset (rst=1 at a clk edge) overrides all other activity, including reset asserted mid-burst. Resulting state:
  - wptr=0, rptr=0, count=0
  - dout=0, dout_valid=0, overflow=0, underflow=0
  - so empty=1, full=0, almost_empty=1, almost_full=0
  - memory contents are not cleared and are unobservable after reset
- Acceptance uses the flags as they stand before the edge:
  - wr_acc = wr & !full
  - rd_acc = rd & !empty
- Write: on wr_acc, mem[wptr] <= din and wptr increments modulo DEPTH (natural AW-bit wrap).
- Read: on rd_acc, dout <= mem[rptr], rptr increments modulo DEPTH, and dout_valid=1 in the following cycle. Read latency is 1 cycle. When there is no rd_acc, dout holds its last value and dout_valid=0.
- count update:
  - +1 on wr_acc only
  - -1 on rd_acc only
  - unchanged when both or neither are accepted
- Simultaneous wr & rd:
  - Not empty and not full: both accepted; count unchanged.
  - Empty: write accepted, read rejected. underflow sets; no bypass of din to dout.
  - Full: read accepted, write rejected. overflow sets. The slot freed by the read is not reused in the same cycle.
- Error flags:
  - overflow <= 1 when wr & full; underflow <= 1 when rd & empty.
  - Both hold until rst; no other clear path.
  - A rejected request changes no pointer, count or memory.
- Status flags are combinational decodes of the registered count (no extra latency) and update the cycle after the edge that changes count.
- Data ordering is strict FIFO. Words read equal words written, in order, across any number of pointer wraps.
- Parameter legality is checked at elaboration; an illegal DEPTH, AF_LEVEL or AE_LEVEL is a fatal error.
- Estimated implementation size is about 150 lines of RTL.

Test Plan:
1. Defaults (WIDTH=8, DEPTH=16, AF=14, AE=2). Reset, then write 0x01..0x10 (16 writes) -> count steps 1..16; almost_empty deasserts at count=3; almost_full asserts at count=14; full=1 at 16; overflow stays 0.
2. From full, write 0xAA once, then read 16 words -> overflow=1 (sticky); dout = 0x01..0x10 in order, each one cycle after its rd; dout_valid pulses 16 times; empty=1 at end; 0xAA never appears.
3. Empty FIFO with rd=1 and wr=1 (din=0x5A) in the same cycle -> underflow=1, count=1, dout_valid=0. Next cycle rd=1 -> dout=0x5A with dout_valid=1.
4. Hold count at 8, drive wr&rd together for 40 cycles with an incrementing din -> count stays 8; pointers wrap at least twice; the read stream equals the write stream delayed by 8 words; no error flags set.
5. At count=10, assert rst for one cycle during wr=1 and rd=1 -> next cycle count=0, empty=1, dout=0, dout_valid=0, overflow=underflow=0. The first subsequent write/read pair returns the new data.
6. Re-parametrise to WIDTH=32, DEPTH=4, AF_LEVEL=4, AE_LEVEL=0 -> almost_full coincides with full; almost_empty coincides with empty. Write 0xDEADBEEF and read it back -> dout=0xDEADBEEF.
